// File: rtl/mem_bridge.sv
// M-stage memory bridge: turns a load/store into a single bus transaction and
// holds the pipeline frozen until the bus completes or the access times out.
module mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_rd,
  input  logic [3:0]  i_mem_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_we,
  output logic [31:0] o_bus_wdata,
  output logic [31:0] o_load_data,
  output logic        o_stall,
  output logic        o_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_access;
  logic          w_last;
  logic [31:0]   w_wdata_aln;
  logic [CW-1:0] r_cnt;
  logic          r_rd;
  logic          r_bus_req;
  logic [31:0]   r_bus_addr;
  logic [3:0]    r_bus_we;
  logic [31:0]   r_bus_wdata;
  logic [31:0]   r_load_data;
  logic          r_err;

  assign w_access    = i_mem_rd | (|i_mem_we);
  assign w_last      = (r_cnt == CW'(TIMEOUT - 1));
  assign w_wdata_aln = i_wdata << {i_addr[1:0], 3'b000};

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_access) w_next = S_BUSY;
      S_BUSY:  if (i_bus_ready || w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // DONE releases the stall so the pipeline advances while load_data is valid
  always_comb begin
    o_stall = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_IDLE:  o_stall = w_access;
        S_BUSY:  o_stall = 1'b1;
        default: o_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_rd        <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_we    <= '0;
      r_bus_wdata <= '0;
      r_load_data <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_bus_req   <= 1'b1;
            r_bus_addr  <= {i_addr[31:2], 2'b00};
            r_bus_we    <= i_mem_we;
            r_bus_wdata <= w_wdata_aln;
            r_rd        <= i_mem_rd;
            r_cnt       <= '0;
          end
        end
        S_BUSY: begin
          // a completion in the last allowed cycle beats the timeout
          if (i_bus_ready) begin
            r_bus_req <= 1'b0;
            if (r_rd) r_load_data <= i_bus_rdata;
          end else if (w_last) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            if (r_rd) r_load_data <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_bus_req   = r_bus_req;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_we    = r_bus_we;
  assign o_bus_wdata = r_bus_wdata;
  assign o_load_data = r_load_data;
  assign o_err       = r_err;

endmodule
